hack_ram_dp: RTL and testbench
==============================

Name: hack_ram_dp

Overview:
Parametrised dual-port successor to the Hack data-memory RAM, for the HackComputer memory map.
- Port A: read/write, combinational read, used by the CPU datapath.
- Port B: read-only, registered read with valid strobe, used by the screen/debug readers.
- After every reset, a built-in init sequencer clears the array to INIT_VALUE, one word per cycle, before accepting traffic.

Parameters:
DATA_W, 16, word width in bits.
DEPTH, 16384, number of words; any value >= 2, not necessarily a power of 2.
ADDR_W, $clog2(DEPTH), address width (derived; not overridden).
INIT_VALUE, 0, word written to every location by the init sequencer.
WRITE_FIRST, 1, port-B collision policy: 1 = return new data, 0 = return old data.

Ports:
clk  input  1  system clock, all state on rising edge
reset_n  input  1  asynchronous, active-low reset
ready  output  1  high when init is complete and ports are serviced
addr_a  input  ADDR_W  port A address
in_a  input  DATA_W  port A write data
load_a  input  1  port A write enable
out_a  output  DATA_W  port A combinational read data
addr_b  input  ADDR_W  port B address
rd_en_b  input  1  port B read request
out_b  output  DATA_W  port B registered read data
valid_b  output  1  out_b holds data for the request of the previous cycle

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset is asynchronous, active-low (reset_n); assertion takes effect immediately, deassertion is sampled on clk.
- Reset values: state=INIT, init_cnt=0, ready=0, out_b=0, valid_b=0. Array contents are not reset directly.
- State machine:
  - INIT: each cycle writes mem[init_cnt]=INIT_VALUE and increments init_cnt. When init_cnt==DEPTH-1 is written, go to RUN next cycle. Init takes exactly DEPTH cycles after reset deassertion.
  - RUN: ready=1. Remains in RUN until reset.
- During INIT:
  - load_a is ignored; no write occurs.
  - rd_en_b is ignored; valid_b stays 0.
  - out_a is forced to 0.
- Port A in RUN:
  - out_a = mem[addr_a] combinationally.
  - If load_a=1, mem[addr_a]<=in_a at the rising edge; out_a shows the new value after that edge.
- Port B in RUN:
  - If rd_en_b=1, then on the next edge out_b<=mem[addr_b] and valid_b<=1.
  - If rd_en_b=0, valid_b<=0 and out_b holds its value.
  - Latency is 1 cycle. There is no backpressure; a read can be issued every cycle.
- Collision (load_a && rd_en_b && addr_a==addr_b, same cycle): out_b gets in_a if WRITE_FIRST=1, else the pre-write word.
- Out-of-range address (>= DEPTH when DEPTH is not a power of 2):
  - Writes are dropped.
  - out_a reads 0.
  - Port B returns 0 with valid_b=1.
- Reset mid-init or mid-run: immediately returns to INIT with init_cnt=0 and reruns the full clear. Any in-flight port B read is discarded (valid_b=0).
- init_cnt is ADDR_W bits wide, with a terminal compare against DEPTH-1; no wrap.

Decomposition:
- Shared package hack_mem_pkg:
  - state enum {INIT, RUN}
  - defaults HACK_DATA_W=16, HACK_RAM_DEPTH=16384, HACK_SCREEN_DEPTH=8192
- One natural sub-module, hack_ram_init_seq: FSM plus counter, producing ready, init_we and init_addr.
- Array and port logic stay in hack_ram_dp, which muxes the init write over port A.

Test Plan:
1. Init timing: DEPTH=16, INIT_VALUE=16'hA5A5; release reset_n -> ready rises exactly 16 cycles later. All 16 reads on port B return 16'hA5A5 with valid_b=1.
2. Write then read: in RUN, write addr_a=3, in_a=16'h1234 -> out_a=16'h1234 after the edge. rd_en_b with addr_b=3 -> out_b=16'h1234 and valid_b=1 one cycle later.
3. Collision: write 16'hBEEF to addr 5 (prior content 16'h0001) with a same-cycle B read of addr 5 -> out_b=16'hBEEF when WRITE_FIRST=1, 16'h0001 when WRITE_FIRST=0.
4. Ignored traffic during init: load_a=1 (addr 2, 16'hFFFF) and rd_en_b=1 during INIT -> valid_b stays 0, out_a=0. After ready, addr 2 reads INIT_VALUE.
5. Reset mid-run: write 16'h7777 to addr 7, pulse reset_n low asynchronously (not clock-aligned) -> ready=0 and valid_b=0 immediately. After the new DEPTH-cycle init, addr 7 reads INIT_VALUE.
6. Non-power-of-2 depth and back-to-back reads: DEPTH=10, write addr 12 -> no effect and out_a=0. Issue port B reads of addr 0..9 back to back -> valid_b high on 10 consecutive cycles with the matching data.

Source files
------------

// File: rtl/hack_mem_pkg.sv
// +--------------------------------------------------------------------+
// | hack_mem_pkg : shared types and defaults for the Hack memory map   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

package hack_mem_pkg;

  localparam int HACK_DATA_W       = 16;
  localparam int HACK_RAM_DEPTH    = 16384;
  localparam int HACK_SCREEN_DEPTH = 8192;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  // True when n is an exact power of two (no out-of-range addresses possible).
  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/hack_ram_init_seq.sv
// +--------------------------------------------------------------------+
// | hack_ram_init_seq : post-reset clear sequencer, one word per cycle |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module hack_ram_init_seq
  import hack_mem_pkg::*;
#(
  parameter int DEPTH  = HACK_RAM_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              ready,
  output logic              init_we,
  output logic [ADDR_W-1:0] init_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cnt_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // The counter stops on the last address rather than wrapping.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    init_we   = 1'b0;
    ready     = 1'b0;
    case (state)
      INIT: begin
        init_we = 1'b1;
        if (cnt == LAST_ADDR) begin
          state_nxt = RUN;
        end else begin
          cnt_nxt = cnt + ADDR_W'(1);
        end
      end
      RUN: begin
        ready = 1'b1;
      end
      default: begin
        state_nxt = INIT;
      end
    endcase
  end

  assign init_addr = cnt;

endmodule

`default_nettype wire

// File: rtl/hack_ram_dp.sv
// +--------------------------------------------------------------------+
// | hack_ram_dp : dual-port Hack data RAM (A: r/w comb, B: reg read)   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module hack_ram_dp
  import hack_mem_pkg::*;
#(
  parameter int                DATA_W      = HACK_DATA_W,
  parameter int                DEPTH       = HACK_RAM_DEPTH,
  parameter int                ADDR_W      = $clog2(DEPTH),
  parameter logic [DATA_W-1:0] INIT_VALUE  = '0,
  parameter bit                WRITE_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              ready,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] in_a,
  input  logic              load_a,
  output logic [DATA_W-1:0] out_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic              rd_en_b,
  output logic [DATA_W-1:0] out_b,
  output logic              valid_b
);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              init_we;
  logic [ADDR_W-1:0] init_addr;
  logic              in_range_a;
  logic              in_range_b;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              collide;
  logic              fwd_b;

  hack_ram_init_seq #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_init_seq (
    .clk       (clk),
    .reset_n   (reset_n),
    .ready     (ready),
    .init_we   (init_we),
    .init_addr (init_addr)
  );

  // Only non-power-of-two depths leave part of the address space unmapped.
  if (is_pow2(DEPTH)) begin : g_range_full
    assign in_range_a = 1'b1;
    assign in_range_b = 1'b1;
  end else begin : g_range_check
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    assign in_range_a = ({1'b0, addr_a} < DEPTH_EXT);
    assign in_range_b = ({1'b0, addr_b} < DEPTH_EXT);
  end

  // The init sequencer owns the write port until ready rises.
  assign mem_we    = init_we | (ready & load_a & in_range_a);
  assign mem_waddr = init_we ? init_addr : addr_a;
  assign mem_wdata = init_we ? INIT_VALUE : in_a;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign out_a = (ready && in_range_a) ? mem[addr_a] : '0;

  assign collide = load_a && in_range_a && (addr_a == addr_b);

  // Read-first falls out of the non-blocking array read; write-first forwards in_a.
  if (WRITE_FIRST) begin : g_write_first
    assign fwd_b = collide;
  end else begin : g_read_first
    assign fwd_b = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_b   <= '0;
      valid_b <= 1'b0;
    end else if (ready && rd_en_b) begin
      valid_b <= 1'b1;
      if (!in_range_b) begin
        out_b <= '0;
      end else if (fwd_b) begin
        out_b <= in_a;
      end else begin
        out_b <= mem[addr_b];
      end
    end else begin
      valid_b <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hack_ram_dp.sv
// +--------------------------------------------------------------------+
// | tb_hack_ram_dp : directed self-checking bench for hack_ram_dp      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_hack_ram_dp;

  localparam logic [15:0] IV0 = 16'hA5A5;
  localparam logic [15:0] IV1 = 16'h5A5A;
  localparam logic [15:0] IV2 = 16'h0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // u0: DEPTH 16, write-first; u1: DEPTH 16, read-first; u2: DEPTH 10
  logic        rst0_n, load_a0, rd_en_b0, ready0, valid_b0;
  logic [3:0]  addr_a0, addr_b0;
  logic [15:0] in_a0, out_a0, out_b0;
  logic        rst1_n, load_a1, rd_en_b1, ready1, valid_b1;
  logic [3:0]  addr_a1, addr_b1;
  logic [15:0] in_a1, out_a1, out_b1;
  logic        rst2_n, load_a2, rd_en_b2, ready2, valid_b2;
  logic [3:0]  addr_a2, addr_b2;
  logic [15:0] in_a2, out_a2, out_b2;

  hack_ram_dp #(.DATA_W(16), .DEPTH(16), .INIT_VALUE(IV0), .WRITE_FIRST(1'b1)) u0 (
    .clk(clk), .reset_n(rst0_n), .ready(ready0),
    .addr_a(addr_a0), .in_a(in_a0), .load_a(load_a0), .out_a(out_a0),
    .addr_b(addr_b0), .rd_en_b(rd_en_b0), .out_b(out_b0), .valid_b(valid_b0)
  );

  hack_ram_dp #(.DATA_W(16), .DEPTH(16), .INIT_VALUE(IV1), .WRITE_FIRST(1'b0)) u1 (
    .clk(clk), .reset_n(rst1_n), .ready(ready1),
    .addr_a(addr_a1), .in_a(in_a1), .load_a(load_a1), .out_a(out_a1),
    .addr_b(addr_b1), .rd_en_b(rd_en_b1), .out_b(out_b1), .valid_b(valid_b1)
  );

  hack_ram_dp #(.DATA_W(16), .DEPTH(10), .INIT_VALUE(IV2), .WRITE_FIRST(1'b1)) u2 (
    .clk(clk), .reset_n(rst2_n), .ready(ready2),
    .addr_a(addr_a2), .in_a(in_a2), .load_a(load_a2), .out_a(out_a2),
    .addr_b(addr_b2), .rd_en_b(rd_en_b2), .out_b(out_b2), .valid_b(valid_b2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst0_n = 1'b0; rst1_n = 1'b0; rst2_n = 1'b0;
    load_a0 = 1'b0; rd_en_b0 = 1'b0; addr_a0 = '0; addr_b0 = '0; in_a0 = '0;
    load_a1 = 1'b0; rd_en_b1 = 1'b0; addr_a1 = '0; addr_b1 = '0; in_a1 = '0;
    load_a2 = 1'b0; rd_en_b2 = 1'b0; addr_a2 = '0; addr_b2 = '0; in_a2 = '0;
    tick();
    tick();
    checks++;
    if (ready0 !== 1'b0 || valid_b0 !== 1'b0 || out_b0 !== 16'h0 || out_a0 !== 16'h0) begin
      errors++;
      $display("FAIL reset_u0: ready=%b valid_b=%b out_b=%h out_a=%h, required 0 0 0000 0000",
               ready0, valid_b0, out_b0, out_a0);
    end
    checks++;
    if (ready2 !== 1'b0 || valid_b2 !== 1'b0 || out_b2 !== 16'h0) begin
      errors++;
      $display("FAIL reset_u2: ready=%b valid_b=%b out_b=%h, required 0 0 0000",
               ready2, valid_b2, out_b2);
    end
  endtask

  // Release reset with traffic driven on u0 that must be ignored during init.
  task automatic test_init_timing();
    int r0 = 0;
    int r1 = 0;
    int r2 = 0;
    load_a0 = 1'b1; addr_a0 = 4'd2; in_a0 = 16'hFFFF;
    rd_en_b0 = 1'b1; addr_b0 = 4'd2;
    rst0_n = 1'b1; rst1_n = 1'b1; rst2_n = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (ready0 && r0 == 0) r0 = n;
      if (ready1 && r1 == 0) r1 = n;
      if (ready2 && r2 == 0) r2 = n;
      if (!ready0) begin
        checks++;
        if (valid_b0 !== 1'b0 || out_a0 !== 16'h0) begin
          errors++;
          $display("FAIL init_ignore cycle %0d: valid_b=%b out_a=%h, required 0 0000",
                   n, valid_b0, out_a0);
        end
      end
      if (r0 != 0 && r1 != 0 && r2 != 0) break;
    end
    load_a0 = 1'b0; rd_en_b0 = 1'b0;
    checks++;
    if (r0 != 16 || r1 != 16 || r2 != 10) begin
      errors++;
      $display("FAIL init_latency: u0=%0d u1=%0d u2=%0d cycles, required 16 16 10", r0, r1, r2);
    end
    #1;
    checks++;
    if (out_a0 !== IV0) begin
      errors++;
      $display("FAIL init_ignored_write: out_a[2]=%h, required %h", out_a0, IV0);
    end
  endtask

  task automatic test_init_contents();
    for (int i = 0; i < 16; i++) begin
      addr_b0 = 4'(i); rd_en_b0 = 1'b1;
      tick();
      checks++;
      if (valid_b0 !== 1'b1 || out_b0 !== IV0) begin
        errors++;
        $display("FAIL init_contents addr %0d: valid_b=%b out_b=%h, required 1 %h",
                 i, valid_b0, out_b0, IV0);
      end
    end
    rd_en_b0 = 1'b0;
    tick();
    checks++;
    if (valid_b0 !== 1'b0 || out_b0 !== IV0) begin
      errors++;
      $display("FAIL idle_hold: valid_b=%b out_b=%h, required 0 %h", valid_b0, out_b0, IV0);
    end
  endtask

  task automatic test_write_read();
    addr_a0 = 4'd3; in_a0 = 16'h1234; load_a0 = 1'b1;
    #1;
    checks++;
    if (out_a0 !== IV0) begin
      errors++;
      $display("FAIL write_pre_edge: out_a=%h, required %h", out_a0, IV0);
    end
    tick();
    load_a0 = 1'b0;
    checks++;
    if (out_a0 !== 16'h1234) begin
      errors++;
      $display("FAIL write_post_edge: out_a=%h, required 1234", out_a0);
    end
    addr_b0 = 4'd3; rd_en_b0 = 1'b1;
    tick();
    rd_en_b0 = 1'b0;
    checks++;
    if (valid_b0 !== 1'b1 || out_b0 !== 16'h1234) begin
      errors++;
      $display("FAIL read_b: valid_b=%b out_b=%h, required 1 1234", valid_b0, out_b0);
    end
  endtask

  task automatic test_collision();
    addr_a0 = 4'd5; in_a0 = 16'h0001; load_a0 = 1'b1;
    addr_a1 = 4'd5; in_a1 = 16'h0001; load_a1 = 1'b1;
    tick();
    in_a0 = 16'hBEEF; addr_b0 = 4'd5; rd_en_b0 = 1'b1;
    in_a1 = 16'hBEEF; addr_b1 = 4'd5; rd_en_b1 = 1'b1;
    tick();
    load_a0 = 1'b0; rd_en_b0 = 1'b0;
    load_a1 = 1'b0; rd_en_b1 = 1'b0;
    checks++;
    if (valid_b0 !== 1'b1 || out_b0 !== 16'hBEEF) begin
      errors++;
      $display("FAIL collision_wf: valid_b=%b out_b=%h, required 1 beef", valid_b0, out_b0);
    end
    checks++;
    if (valid_b1 !== 1'b1 || out_b1 !== 16'h0001) begin
      errors++;
      $display("FAIL collision_rf: valid_b=%b out_b=%h, required 1 0001", valid_b1, out_b1);
    end
    checks++;
    if (out_a1 !== 16'hBEEF) begin
      errors++;
      $display("FAIL collision_rf_write: out_a=%h, required beef", out_a1);
    end
  endtask

  task automatic test_reset_midrun();
    int r0 = 0;
    addr_a0 = 4'd7; in_a0 = 16'h7777; load_a0 = 1'b1;
    tick();
    load_a0 = 1'b0;
    addr_b0 = 4'd7; rd_en_b0 = 1'b1;
    tick();
    checks++;
    if (valid_b0 !== 1'b1 || out_b0 !== 16'h7777) begin
      errors++;
      $display("FAIL pre_reset_read: valid_b=%b out_b=%h, required 1 7777", valid_b0, out_b0);
    end
    #3;
    rst0_n = 1'b0;
    #1;
    checks++;
    if (ready0 !== 1'b0 || valid_b0 !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: ready=%b valid_b=%b, required 0 0", ready0, valid_b0);
    end
    rd_en_b0 = 1'b0;
    tick();
    tick();
    rst0_n = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (ready0) begin
        r0 = n;
        break;
      end
    end
    checks++;
    if (r0 != 16) begin
      errors++;
      $display("FAIL reinit_latency: %0d cycles, required 16", r0);
    end
    #1;
    checks++;
    if (out_a0 !== IV0) begin
      errors++;
      $display("FAIL reinit_clear: out_a[7]=%h, required %h", out_a0, IV0);
    end
  endtask

  task automatic test_nonpow2();
    for (int i = 0; i < 10; i++) begin
      addr_a2 = 4'(i); in_a2 = 16'h0C00 + 16'(i); load_a2 = 1'b1;
      tick();
    end
    addr_a2 = 4'd12; in_a2 = 16'hBAD1; load_a2 = 1'b1;
    #1;
    checks++;
    if (out_a2 !== 16'h0) begin
      errors++;
      $display("FAIL oor_out_a_pre: out_a=%h, required 0000", out_a2);
    end
    tick();
    load_a2 = 1'b0;
    checks++;
    if (out_a2 !== 16'h0) begin
      errors++;
      $display("FAIL oor_out_a_post: out_a=%h, required 0000", out_a2);
    end
    addr_b2 = 4'd12; rd_en_b2 = 1'b1;
    tick();
    checks++;
    if (valid_b2 !== 1'b1 || out_b2 !== 16'h0) begin
      errors++;
      $display("FAIL oor_read_b: valid_b=%b out_b=%h, required 1 0000", valid_b2, out_b2);
    end
    for (int i = 0; i < 10; i++) begin
      addr_b2 = 4'(i); rd_en_b2 = 1'b1;
      tick();
      checks++;
      if (valid_b2 !== 1'b1 || out_b2 !== (16'h0C00 + 16'(i))) begin
        errors++;
        $display("FAIL b2b_read addr %0d: valid_b=%b out_b=%h, required 1 %h",
                 i, valid_b2, out_b2, 16'h0C00 + 16'(i));
      end
    end
    rd_en_b2 = 1'b0;
    tick();
    checks++;
    if (valid_b2 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: valid_b=%b, required 0", valid_b2);
    end
  endtask

  initial begin
    test_reset();
    test_init_timing();
    test_init_contents();
    test_write_read();
    test_collision();
    test_reset_midrun();
    test_nonpow2();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
